// File: rtl/trans_sched_ipa_pkg.sv
// Shared types and constants for the transaction scheduler: FSM states and
// TX/RX command type encoding.
package trans_sched_ipa_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic TYPE_TX = 1'b0;
    localparam logic TYPE_RX = 1'b1;

endpackage

// File: rtl/trans_chunk_calc_ipa.sv
// Combinational size of the next transaction. With TRANS_SCHED_BOUNDARY_SPLIT_EN
// defined, a transaction never crosses a MAX_BURST_BYTES-aligned ext address.
module trans_chunk_calc_ipa #(
    parameter int unsigned LEN_WIDTH       = 15,
    parameter int unsigned MAX_BURST_BYTES = 256
) (
    input  logic [LEN_WIDTH-1:0] remaining,
    input  logic [31:0]          ext_addr,
    output logic [LEN_WIDTH-1:0] chunk
);

    localparam int unsigned OFS_W = $clog2(MAX_BURST_BYTES);

    logic [31:0] room;
    logic [31:0] rem_ext;
    logic        ext_unused;

`ifdef TRANS_SCHED_BOUNDARY_SPLIT_EN
    // Bytes left before the next aligned boundary: 1..MAX_BURST_BYTES.
    assign room = 32'(MAX_BURST_BYTES) - 32'(ext_addr[OFS_W-1:0]);
`else
    assign room = 32'(MAX_BURST_BYTES);
`endif

    assign ext_unused = ^ext_addr;
    assign rem_ext    = 32'(remaining);
    assign chunk      = (rem_ext < room) ? remaining : LEN_WIDTH'(room);

endmodule

// File: rtl/trans_sched_ipa.sv
// Splits a TX/RX byte-length command into bursts of at most MAX_BURST_BYTES
// and issues them one per cycle on the selected direction's trans port.
// Optional ext-address boundary splitting: TRANS_SCHED_BOUNDARY_SPLIT_EN.
module trans_sched_ipa
    import trans_sched_ipa_pkg::*;
#(
    parameter int unsigned MCHAN_LEN_WIDTH = 15,
    parameter int unsigned MAX_BURST_BYTES = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_i,

    input  logic                       cmd_req_i,
    output logic                       cmd_gnt_o,
    input  logic                       cmd_type_i,
    input  logic [MCHAN_LEN_WIDTH-1:0] cmd_len_i,
    input  logic [31:0]                cmd_tcdm_addr_i,
    input  logic [31:0]                cmd_ext_addr_i,

    output logic                       tx_trans_req_o,
    input  logic                       tx_trans_gnt_i,
    output logic [31:0]                tx_trans_tcdm_addr_o,
    output logic [31:0]                tx_trans_ext_addr_o,
    output logic [MCHAN_LEN_WIDTH-1:0] tx_trans_len_o,

    output logic                       rx_trans_req_o,
    input  logic                       rx_trans_gnt_i,
    output logic [31:0]                rx_trans_tcdm_addr_o,
    output logic [31:0]                rx_trans_ext_addr_o,
    output logic [MCHAN_LEN_WIDTH-1:0] rx_trans_len_o,

    output logic                       busy_o,
    output logic                       cmd_done_o
);

    state_t                     state_q, state_d;
    logic                       type_q, type_d;
    logic [MCHAN_LEN_WIDTH-1:0] rem_q, rem_d;
    logic [31:0]                tcdm_q, tcdm_d;
    logic [31:0]                ext_q, ext_d;
    logic                       done_q, done_d;

    logic [MCHAN_LEN_WIDTH-1:0] chunk;
    logic                       issue;
    logic                       sel_gnt;

    trans_chunk_calc_ipa #(
        .LEN_WIDTH       (MCHAN_LEN_WIDTH),
        .MAX_BURST_BYTES (MAX_BURST_BYTES)
    ) u_chunk (
        .remaining (rem_q),
        .ext_addr  (ext_q),
        .chunk     (chunk)
    );

    assign issue   = (state_q == ISSUE);
    // Only the selected direction's grant can advance the command.
    assign sel_gnt = (type_q == TYPE_RX) ? rx_trans_gnt_i : tx_trans_gnt_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            type_q  <= TYPE_TX;
            rem_q   <= '0;
            tcdm_q  <= '0;
            ext_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            rem_q   <= rem_d;
            tcdm_q  <= tcdm_d;
            ext_q   <= ext_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        rem_d   = rem_q;
        tcdm_d  = tcdm_q;
        ext_d   = ext_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_req_i) begin
                    type_d = cmd_type_i;
                    rem_d  = cmd_len_i;
                    tcdm_d = cmd_tcdm_addr_i;
                    ext_d  = cmd_ext_addr_i;
                    // Zero-length commands complete without entering ISSUE.
                    if (cmd_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (sel_gnt) begin
                    tcdm_d = tcdm_q + 32'(chunk);
                    ext_d  = ext_q + 32'(chunk);
                    rem_d  = rem_q - chunk;
                    if (rem_q == chunk) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_gnt_o  = (state_q == IDLE);
    assign busy_o     = issue;
    assign cmd_done_o = done_q;

    assign tx_trans_req_o       = issue && (type_q == TYPE_TX);
    assign tx_trans_tcdm_addr_o = tx_trans_req_o ? tcdm_q : '0;
    assign tx_trans_ext_addr_o  = tx_trans_req_o ? ext_q : '0;
    assign tx_trans_len_o       = tx_trans_req_o ? chunk : '0;

    assign rx_trans_req_o       = issue && (type_q == TYPE_RX);
    assign rx_trans_tcdm_addr_o = rx_trans_req_o ? tcdm_q : '0;
    assign rx_trans_ext_addr_o  = rx_trans_req_o ? ext_q : '0;
    assign rx_trans_len_o       = rx_trans_req_o ? chunk : '0;

endmodule

// File: tb/tb_trans_sched_ipa.sv
// Directed bench for trans_sched_ipa (MAX_BURST_BYTES=256); expectations
// follow TRANS_SCHED_BOUNDARY_SPLIT_EN when it is defined.
module tb_trans_sched_ipa;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_req_i;
    logic        cmd_gnt_o;
    logic        cmd_type_i;
    logic [14:0] cmd_len_i;
    logic [31:0] cmd_tcdm_addr_i;
    logic [31:0] cmd_ext_addr_i;
    logic        tx_trans_req_o;
    logic        tx_trans_gnt_i;
    logic [31:0] tx_trans_tcdm_addr_o;
    logic [31:0] tx_trans_ext_addr_o;
    logic [14:0] tx_trans_len_o;
    logic        rx_trans_req_o;
    logic        rx_trans_gnt_i;
    logic [31:0] rx_trans_tcdm_addr_o;
    logic [31:0] rx_trans_ext_addr_o;
    logic [14:0] rx_trans_len_o;
    logic        busy_o;
    logic        cmd_done_o;

    int total = 0;
    int bad   = 0;

    trans_sched_ipa #(
        .MCHAN_LEN_WIDTH (15),
        .MAX_BURST_BYTES (256)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .cmd_req_i            (cmd_req_i),
        .cmd_gnt_o            (cmd_gnt_o),
        .cmd_type_i           (cmd_type_i),
        .cmd_len_i            (cmd_len_i),
        .cmd_tcdm_addr_i      (cmd_tcdm_addr_i),
        .cmd_ext_addr_i       (cmd_ext_addr_i),
        .tx_trans_req_o       (tx_trans_req_o),
        .tx_trans_gnt_i       (tx_trans_gnt_i),
        .tx_trans_tcdm_addr_o (tx_trans_tcdm_addr_o),
        .tx_trans_ext_addr_o  (tx_trans_ext_addr_o),
        .tx_trans_len_o       (tx_trans_len_o),
        .rx_trans_req_o       (rx_trans_req_o),
        .rx_trans_gnt_i       (rx_trans_gnt_i),
        .rx_trans_tcdm_addr_o (rx_trans_tcdm_addr_o),
        .rx_trans_ext_addr_o  (rx_trans_ext_addr_o),
        .rx_trans_len_o       (rx_trans_len_o),
        .busy_o               (busy_o),
        .cmd_done_o           (cmd_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_cmd(input logic typ, input logic [14:0] len,
                            input logic [31:0] tcdm, input logic [31:0] ext);
        chk("cmd_gnt_idle", 64'(cmd_gnt_o), 64'd1);
        cmd_req_i       = 1'b1;
        cmd_type_i      = typ;
        cmd_len_i       = len;
        cmd_tcdm_addr_i = tcdm;
        cmd_ext_addr_i  = ext;
        step();
        cmd_req_i = 1'b0;
    endtask

    task automatic chk_tx(input string tag, input logic [14:0] len,
                          input logic [31:0] ext, input logic [31:0] tcdm);
        chk({tag, "_txreq"}, 64'(tx_trans_req_o), 64'd1);
        chk({tag, "_rxreq"}, 64'(rx_trans_req_o), 64'd0);
        chk({tag, "_len"},   64'(tx_trans_len_o), 64'(len));
        chk({tag, "_ext"},   64'(tx_trans_ext_addr_o), 64'(ext));
        chk({tag, "_tcdm"},  64'(tx_trans_tcdm_addr_o), 64'(tcdm));
        chk({tag, "_busy"},  64'(busy_o), 64'd1);
        chk({tag, "_gnt"},   64'(cmd_gnt_o), 64'd0);
    endtask

    task automatic chk_rx(input string tag, input logic [14:0] len,
                          input logic [31:0] ext, input logic [31:0] tcdm);
        chk({tag, "_rxreq"}, 64'(rx_trans_req_o), 64'd1);
        chk({tag, "_txreq"}, 64'(tx_trans_req_o), 64'd0);
        chk({tag, "_len"},   64'(rx_trans_len_o), 64'(len));
        chk({tag, "_ext"},   64'(rx_trans_ext_addr_o), 64'(ext));
        chk({tag, "_tcdm"},  64'(rx_trans_tcdm_addr_o), 64'(tcdm));
        chk({tag, "_busy"},  64'(busy_o), 64'd1);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"},  64'(cmd_done_o), 64'd1);
        chk({tag, "_busy0"}, 64'(busy_o), 64'd0);
        chk({tag, "_req0"},  64'({tx_trans_req_o, rx_trans_req_o}), 64'd0);
        step();
        chk({tag, "_done0"}, 64'(cmd_done_o), 64'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_txreq"}, 64'(tx_trans_req_o), 64'd0);
        chk({tag, "_rxreq"}, 64'(rx_trans_req_o), 64'd0);
        chk({tag, "_txflds"}, {tx_trans_tcdm_addr_o, tx_trans_ext_addr_o} | 64'(tx_trans_len_o), 64'd0);
        chk({tag, "_rxflds"}, {rx_trans_tcdm_addr_o, rx_trans_ext_addr_o} | 64'(rx_trans_len_o), 64'd0);
        chk({tag, "_busy"},  64'(busy_o), 64'd0);
        chk({tag, "_done"},  64'(cmd_done_o), 64'd0);
        chk({tag, "_gnt"},   64'(cmd_gnt_o), 64'd1);
    endtask

    initial begin
        rst_i           = 1'b1;
        cmd_req_i       = 1'b0;
        cmd_type_i      = 1'b0;
        cmd_len_i       = '0;
        cmd_tcdm_addr_i = '0;
        cmd_ext_addr_i  = '0;
        tx_trans_gnt_i  = 1'b1;
        rx_trans_gnt_i  = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        chk_reset_state("rst");

        // Single TX transaction
        send_cmd(1'b0, 15'd100, 32'h40, 32'h1000);
        chk_tx("tx100", 15'd100, 32'h1000, 32'h40);
        step();
        chk_done("tx100");

        // RX split into full bursts plus tail
        send_cmd(1'b1, 15'd600, 32'h100, 32'h2000);
        chk_rx("rx600a", 15'd256, 32'h2000, 32'h100);
        step();
        chk_rx("rx600b", 15'd256, 32'h2100, 32'h200);
        step();
        chk_rx("rx600c", 15'd88, 32'h2200, 32'h300);
        step();
        chk_done("rx600");

        // Unaligned ext address near a 256-byte boundary
        send_cmd(1'b0, 15'd64, 32'h0, 32'h10F0);
`ifdef TRANS_SCHED_BOUNDARY_SPLIT_EN
        chk_tx("unal_a", 15'd16, 32'h10F0, 32'h0);
        step();
        chk_tx("unal_b", 15'd48, 32'h1100, 32'h10);
`else
        chk_tx("unal_a", 15'd64, 32'h10F0, 32'h0);
`endif
        step();
        chk_done("unal");

        // Stall: tx grant low for 5 cycles, rx grant toggling must be ignored
        tx_trans_gnt_i = 1'b0;
        send_cmd(1'b0, 15'd300, 32'h500, 32'h3000);
        for (int i = 0; i < 5; i++) begin
            chk_tx($sformatf("stall%0d", i), 15'd256, 32'h3000, 32'h500);
            rx_trans_gnt_i = ~rx_trans_gnt_i;
            step();
        end
        rx_trans_gnt_i = 1'b1;
        tx_trans_gnt_i = 1'b1;
        chk_tx("stall_rel", 15'd256, 32'h3000, 32'h500);
        step();
        chk_tx("stall_tail", 15'd44, 32'h3100, 32'h600);
        step();
        chk_done("stall");

        // Zero-length command
        send_cmd(1'b0, 15'd0, 32'h80, 32'h4000);
        chk("len0_gnt", 64'(cmd_gnt_o), 64'd1);
        chk_done("len0");

        // Reset in the middle of an RX command
        send_cmd(1'b1, 15'd600, 32'h100, 32'h2000);
        chk_rx("rstmid", 15'd256, 32'h2000, 32'h100);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk_reset_state("rstmid_a");
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rstmid_norx%0d", i), 64'({rx_trans_req_o, busy_o, cmd_done_o}), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
